// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front-end stage of the MIPS core. Owns the byte-addressed program counter,
// fetches one 32-bit word at a time from instruction memory, holds it for the
// datapath until accepted, then computes the next PC from the datapath's
// jump/branch outputs. Counts retired instructions and latches a sticky
// fault if the memory never answers a request.
//
// Parameters
//   RESET_VEC      byte address of the first instruction (word aligned)
//   TIMEOUT        REQ cycles tolerated without imem_valid; 0 disables
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous active-low reset
//   imem_req       fetch request (level, registered)
//   imem_addr      fetch byte address, stable while imem_req=1
//   imem_valid     memory response valid (only looked at in REQ)
//   imem_rdata     instruction word, qualified by imem_valid
//   instruction    instruction held for the datapath
//   instr_valid    instruction valid and awaiting acceptance
//   core_ready     datapath completes the held instruction this cycle
//   jump           datapath jump flag for the held instruction
//   branch_success datapath taken-branch flag
//   jump_address   jump index (26 bits) or sign-extended word offset
//   pc_out         byte address of the held instruction
//   retire_count   instructions accepted since reset (wraps)
//   fetch_error    sticky watchdog fault
//   dbg_state      current FSM state (IDLE=0, REQ=1, ISSUE=2, ERROR=3)
//
// Handshakes: a memory transfer completes on a rising edge where
// imem_req=1 and imem_valid=1; an instruction is retired on a rising edge
// where instr_valid=1 and core_ready=1. imem_req and instr_valid are never
// high together, so at most one instruction is in flight.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        core_ready,
    input  logic        jump,
    input  logic        branch_success,
    input  logic [31:0] jump_address,
    output logic [31:0] pc_out,
    output logic [31:0] retire_count,
    output logic        fetch_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state_q,  state_d;
    logic        req_q,    req_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] instr_q,  instr_d;
    logic        ivalid_q, ivalid_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] retire_q, retire_d;
    logic        err_q,    err_d;
    logic [15:0] wait_q,   wait_d;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // Next PC for the held instruction; jump wins over a taken branch.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_address[25:0], 2'b00};
        end else if (branch_success) begin
            next_pc = pc_plus4 + (jump_address << 2);
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        ivalid_d = ivalid_q;
        pc_d     = pc_q;
        retire_d = retire_q;
        err_d    = err_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = RESET_VEC;
            end
            REQ: begin
                // A response on the timeout edge still counts as a success.
                if (imem_valid) begin
                    instr_d  = imem_rdata;
                    ivalid_d = 1'b1;
                    req_d    = 1'b0;
                    pc_d     = addr_q;
                    wait_d   = 16'd0;
                    state_d  = ISSUE;
                end else if ((TIMEOUT != 0) && (wait_q >= TIMEOUT_W)) begin
                    req_d    = 1'b0;
                    ivalid_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ERROR;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    retire_d = retire_q + 32'd1;
                    ivalid_d = 1'b0;
                    req_d    = 1'b1;
                    addr_d   = next_pc;
                    state_d  = REQ;
                end
            end
            ERROR: begin
                // Terminal until reset.
                req_d    = 1'b0;
                ivalid_d = 1'b0;
                err_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= RESET_VEC;
            instr_q  <= 32'd0;
            ivalid_q <= 1'b0;
            pc_q     <= RESET_VEC;
            retire_q <= 32'd0;
            err_q    <= 1'b0;
            wait_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instruction  = instr_q;
    assign instr_valid  = ivalid_q;
    assign pc_out       = pc_q;
    assign retire_count = retire_q;
    assign fetch_error  = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0100;
  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        core_ready;
  logic        jump;
  logic        branch_success;
  logic [31:0] jump_address;
  logic [31:0] pc_out;
  logic [31:0] retire_count;
  logic        fetch_error;
  logic [1:0]  dbg_state;

  instruction_fetch_unit #(
    .RESET_VEC (RV),
    .TIMEOUT   (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .core_ready     (core_ready),
    .jump           (jump),
    .branch_success (branch_success),
    .jump_address   (jump_address),
    .pc_out         (pc_out),
    .retire_count   (retire_count),
    .fetch_error    (fetch_error),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];          // expected fetch addresses, in order
  logic [31:0] exp_retire = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] next_exp();
    if (exp_q.size() != 0) return exp_q.pop_front();
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in REQ: serve the pending request after lat wait states.
  task automatic fetch(input int lat);
    logic [31:0] a;
    a = next_exp();
    check("fetch_addr", imem_addr, a);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    imem_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      step();
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_ivalid", {31'd0, instr_valid}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = inst_of(a);
    step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    check("issue_ivalid", {31'd0, instr_valid}, 32'd1);
    check("issue_instr", instruction, inst_of(a));
    check("issue_pc", pc_out, a);
    check("issue_req", {31'd0, imem_req}, 32'd0);
  endtask

  // Called in ISSUE: retire the held instruction with the given flags.
  task automatic accept(input logic j, input logic b, input logic [31:0] ja,
                        input logic [31:0] exp_next);
    core_ready     = 1'b1;
    jump           = j;
    branch_success = b;
    jump_address   = ja;
    step();
    core_ready     = 1'b0;
    jump           = 1'b0;
    branch_success = 1'b0;
    jump_address   = $urandom;
    exp_retire++;
    exp_q.push_back(exp_next);
    check("acc_retire", retire_count, exp_retire);
    check("acc_ivalid", {31'd0, instr_valid}, 32'd0);
    check("acc_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, RV);
    check({tag, "_instr"}, instruction, 32'd0);
    check({tag, "_ivalid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_pc"}, pc_out, RV);
    check({tag, "_retire"}, retire_count, 32'd0);
    check({tag, "_err"}, {31'd0, fetch_error}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] a;

  initial begin
    rst            = 1'b0;
    imem_valid     = 1'b0;
    imem_rdata     = 32'd0;
    core_ready     = 1'b0;
    jump           = 1'b0;
    branch_success = 1'b0;
    jump_address   = 32'd0;

    // Reset / boot
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(RV);
    step();
    check("boot_req", {31'd0, imem_req}, 32'd1);
    check("boot_ivalid", {31'd0, instr_valid}, 32'd0);
    check("boot_pc", pc_out, RV);
    check("boot_state", {30'd0, dbg_state}, 32'd1);

    // Zero-wait stream with core_ready held high
    imem_valid = 1'b1;
    core_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = next_exp();
      check("stream_addr", imem_addr, a);
      check("stream_req", {31'd0, imem_req}, 32'd1);
      imem_rdata = inst_of(a);
      step();
      imem_rdata = $urandom;
      check("stream_ivalid_hi", {31'd0, instr_valid}, 32'd1);
      check("stream_instr", instruction, inst_of(a));
      check("stream_pc", pc_out, a);
      step();
      exp_retire++;
      exp_q.push_back(a + 32'd4);
      check("stream_ivalid_lo", {31'd0, instr_valid}, 32'd0);
      check("stream_retire", retire_count, exp_retire);
    end
    imem_valid = 1'b0;
    core_ready = 1'b0;
    check("retire_after3", retire_count, 32'd3);

    // 3-cycle memory latency at 0x10C
    fetch(3);

    // Backpressure: ignored valid/jump/branch while core_ready=0
    for (int i = 0; i < 5; i++) begin
      imem_valid     = 1'b1;
      imem_rdata     = $urandom;
      jump           = 1'b1;
      branch_success = 1'b1;
      jump_address   = $urandom;
      step();
      check("bp_instr", instruction, inst_of(32'h10C));
      check("bp_pc", pc_out, 32'h10C);
      check("bp_req", {31'd0, imem_req}, 32'd0);
      check("bp_ivalid", {31'd0, instr_valid}, 32'd1);
      check("bp_retire", retire_count, exp_retire);
    end
    imem_valid     = 1'b0;
    jump           = 1'b0;
    branch_success = 1'b0;

    // Control-flow table
    accept(1'b0, 1'b1, 32'h03FF_FFC0, 32'h1000_0010);  // branch far forward
    fetch(0);
    accept(1'b1, 1'b1, 32'h0000_0040, 32'h1000_0100);  // jump beats branch
    fetch(1);
    accept(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1FFF_FFFC);  // jump keeps only 26 bits
    fetch(0);
    accept(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2000_0000);  // sequential, target ignored
    fetch(0);
    accept(1'b0, 1'b1, 32'hF800_007F, 32'h0000_0200);  // backward branch, wraps
    fetch(2);
    accept(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_01FC);  // branch -2 words
    fetch(0);
    accept(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0200);  // branch +0
    fetch(0);
    accept(1'b0, 1'b1, 32'h0000_0003, 32'h0000_0210);  // branch +3 words
    fetch(0);
    accept(1'b0, 1'b1, 32'h3FFF_FF7A, 32'hFFFF_FFFC);  // branch to top of space
    fetch(0);
    accept(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);  // sequential wrap

    // Watchdog: no response at 0x0
    a = next_exp();
    check("wd_addr", imem_addr, a);
    imem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wd_pre_err", {31'd0, fetch_error}, 32'd0);
      check("wd_pre_req", {31'd0, imem_req}, 32'd1);
    end
    step();
    check("wd_err", {31'd0, fetch_error}, 32'd1);
    check("wd_req", {31'd0, imem_req}, 32'd0);
    check("wd_ivalid", {31'd0, instr_valid}, 32'd0);
    check("wd_state", {30'd0, dbg_state}, 32'd3);
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("err_sticky", {31'd0, fetch_error}, 32'd1);
      check("err_ivalid", {31'd0, instr_valid}, 32'd0);
      check("err_req", {31'd0, imem_req}, 32'd0);
    end
    imem_valid = 1'b0;

    // Reset pulse clears the fault and restarts at RESET_VEC
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("pulse");
    @(negedge clk);
    rst = 1'b1;
    exp_retire = 32'd0;
    exp_q.delete();
    exp_q.push_back(RV);
    step();
    a = next_exp();
    check("restart_addr", imem_addr, a);
    check("restart_req", {31'd0, imem_req}, 32'd1);

    // Response on the timeout edge wins over the fault
    for (int i = 0; i < 4; i++) begin
      step();
      check("edge_pre_err", {31'd0, fetch_error}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = inst_of(RV);
    step();
    imem_valid = 1'b0;
    check("edge_ivalid", {31'd0, instr_valid}, 32'd1);
    check("edge_err", {31'd0, fetch_error}, 32'd0);
    check("edge_instr", instruction, inst_of(RV));
    accept(1'b0, 1'b0, 32'h0000_0000, RV + 32'd4);

    // Reset asserted during REQ acts without a clock edge
    step();
    a = next_exp();
    check("mid_addr", imem_addr, a);
    check("mid_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async");
    imem_valid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_idle_ivalid", {31'd0, instr_valid}, 32'd0);
    check("post_idle_req", {31'd0, imem_req}, 32'd1);
    check("post_idle_addr", imem_addr, RV);
    step();
    imem_valid = 1'b0;
    check("post_req_ivalid", {31'd0, instr_valid}, 32'd1);
    check("post_req_instr", instruction, 32'hCAFE_F00D);
    check("post_req_pc", pc_out, RV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end stage of the MIPS core: owns the byte-addressed program counter, fetches 32-bit words from an instruction memory over a request/valid handshake, and presents one instruction at a time to the datapath. It consumes the datapath's `jump`, `branch_success` and `jump_address` outputs to compute the next PC, and counts retired instructions. It detects a stalled memory with a watchdog and latches a sticky fault.

## Interface
- `RESET_VEC`, 32'h0000_0000, byte address of the first instruction (word aligned)
- `TIMEOUT`, 255, cycles allowed in REQ without `imem_valid` before fault; 0 disables; range 0..65535

- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request, level, registered
- `imem_addr`  out  32  fetch byte address, registered, stable while `imem_req`=1
- `imem_valid`  in  1  memory response valid
- `imem_rdata`  in  32  instruction word, qualified by `imem_valid`
- `instruction`  out  32  instruction held for the datapath
- `instr_valid`  out  1  `instruction` is valid and awaiting acceptance
- `core_ready`  in  1  datapath completes the held instruction this cycle
- `jump`  in  1  datapath jump flag for the held instruction
- `branch_success`  in  1  datapath taken-branch flag
- `jump_address`  in  32  datapath target field (26-bit index for jumps, sign-extended word offset for branches)
- `pc_out`  out  32  byte address of the held instruction
- `retire_count`  out  32  instructions accepted since reset, wraps modulo 2^32
- `fetch_error`  out  1  sticky watchdog fault

## Operation
- State machine: IDLE, REQ, ISSUE, ERROR. Reset state is IDLE.
- IDLE:
  - Lasts exactly one cycle.
  - Next edge → REQ, `imem_req`<=1, `imem_addr`<=`RESET_VEC`.
- REQ:
  - `imem_req`=1 throughout.
  - On an edge with `imem_valid`=1: `instruction`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, `pc_out`<=`imem_addr`, wait counter cleared, → ISSUE.
  - Otherwise the 16-bit wait counter increments.
  - If `TIMEOUT`≠0 and the counter has reached `TIMEOUT` → ERROR.
- ISSUE:
  - `instr_valid`=1; `instruction` and `pc_out` held stable.
  - On an edge with `core_ready`=1: `retire_count`++, `instr_valid`<=0, `imem_req`<=1, `imem_addr`<=next PC, → REQ.
- Next PC is computed from the inputs sampled at the accepting edge. Let p4 = `pc_out`+4.
  - `jump`=1 (takes priority over branch): {p4[31:28], `jump_address`[25:0], 2'b00}.
  - Else `branch_success`=1: p4 + (`jump_address`<<2), 32-bit, overflow wraps.
  - Else: p4, with 32-bit wrap (0xFFFF_FFFC → 0x0000_0000).
- ERROR:
  - `imem_req`=0, `instr_valid`=0, `fetch_error`=1.
  - Exit only by reset.
- `imem_valid` is ignored outside REQ.
- `jump`, `branch_success` and `jump_address` are ignored unless ISSUE and `core_ready`=1.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_VEC`, `instruction`=0, `instr_valid`=0.
  - `pc_out`=`RESET_VEC`, `retire_count`=0, `fetch_error`=0.
  - Wait counter=0, state=IDLE.
- Reset asserted mid-operation returns every register to these values immediately, regardless of clock, including during REQ with a response in flight. A response arriving after reset release is ignored unless the block is in REQ.
- First `imem_req` is high after the first rising edge following reset release.
- Zero-wait memory (`imem_valid` in the first REQ cycle): `instr_valid` rises one cycle after `imem_req`.
- With `core_ready` held at 1, throughput is one instruction per 2 cycles; each wait state adds 1 cycle.
- Simultaneous `jump`=1 and `branch_success`=1: jump target is used.
- Watchdog: with `TIMEOUT`=N, ERROR is entered on the (N+1)th consecutive REQ edge without `imem_valid`. A valid on that same edge wins (no fault).
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset/boot: `RESET_VEC`=0x100, release `rst` → after 1 edge `imem_req`=1, `imem_addr`=0x100; all other outputs at reset values.
- Sequential stream, zero-wait memory, `core_ready`=1 → `imem_addr` sequence 0x100, 0x104, 0x108; `instr_valid` toggles every cycle; `retire_count`=3 after third acceptance.
- Jump: `pc_out`=0x1000_0010, `jump`=1, `jump_address`=0x0000_0040 → next `imem_addr`=0x1000_0100. Same accept with `branch_success`=1 also set → still 0x1000_0100.
- Branch: `pc_out`=0x200, `branch_success`=1, `jump_address`=0xFFFF_FFFE → next 0x1FC. With `jump_address`=3 → next 0x210.
- Backpressure and wait states:
  - `core_ready`=0 for 5 cycles → `instruction` and `pc_out` stable, `imem_req`=0, no increment.
  - 3-cycle memory latency → `instr_valid` rises 4 cycles after `imem_req`.
- Watchdog and reset:
  - `TIMEOUT`=4, `imem_valid` held 0 → `fetch_error`=1 after 5 REQ edges, `imem_req`=0.
  - Pulse `rst` → `fetch_error`=0, fetch restarts at `RESET_VEC`.
  - Assert `rst` during REQ → all outputs at reset values without a clock edge.
